// File: rtl/lsu_sequencer.sv
// Data-memory initiator for SIMD load/store: walks the enabled lanes in
// ascending order, issuing one single-port memory access per lane.
module lsu_sequencer #(
    parameter int unsigned N_LANES            = 4,
    parameter int unsigned DATA_WORD_LENGTH   = 8,
    parameter int unsigned DATAMEM_ADDR_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  is_store,
    input  logic [N_LANES-1:0]                    lane_mask,
    input  logic [N_LANES*DATAMEM_ADDR_WIDTH-1:0] lane_addr,
    input  logic [N_LANES*DATA_WORD_LENGTH-1:0]   lane_wdata,
    output logic                                  busy,
    output logic                                  done,
    output logic [N_LANES*DATA_WORD_LENGTH-1:0]   lane_rdata,
    output logic                                  mem_write,
    output logic [DATAMEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WORD_LENGTH-1:0]           mem_wdata,
    input  logic [DATA_WORD_LENGTH-1:0]           mem_rdata
);

    localparam int unsigned DW    = DATA_WORD_LENGTH;
    localparam int unsigned AW    = DATAMEM_ADDR_WIDTH;
    localparam int unsigned PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 st_store_q;
    logic [N_LANES-1:0]   st_mask_q;
    logic [AW-1:0]        st_addr_q  [N_LANES];
    logic [DW-1:0]        st_wdata_q [N_LANES];
    logic [DW-1:0]        rdata_q    [N_LANES];
    logic [AW-1:0]        in_addr    [N_LANES];
    logic [DW-1:0]        in_wdata   [N_LANES];
    logic [N_LANES-1:0]   rem_mask;
    logic                 latch;
    logic                 mem_write_d;
    logic [AW-1:0]        mem_addr_d;
    logic [DW-1:0]        mem_wdata_d;

    // Flat port buses <-> per-lane arrays
    for (genvar g = 0; g < int'(N_LANES); g++) begin : g_lane
        assign in_addr[g]               = lane_addr[g*AW +: AW];
        assign in_wdata[g]              = lane_wdata[g*DW +: DW];
        assign lane_rdata[g*DW +: DW]   = rdata_q[g];
    end

    // Index of the lowest set bit (0 when the mask is empty)
    function automatic logic [PTR_W-1:0] lowest(input logic [N_LANES-1:0] m);
        lowest = '0;
        for (int i = int'(N_LANES) - 1; i >= 0; i--) begin
            if (m[i]) lowest = PTR_W'(i);
        end
    endfunction

    // Enabled lanes strictly above the current pointer
    always_comb begin
        rem_mask = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            rem_mask[i] = st_mask_q[i] & (i > 32'(ptr_q));
        end
    end

    // Next state plus next values of the registered memory-side outputs
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        latch       = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    if (|lane_mask) begin
                        state_d     = ACCESS;
                        ptr_d       = lowest(lane_mask);
                        mem_write_d = is_store;
                        mem_addr_d  = in_addr[ptr_d];
                        mem_wdata_d = is_store ? in_wdata[ptr_d] : '0;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            ACCESS: begin
                if (|rem_mask) begin
                    ptr_d       = lowest(rem_mask);
                    mem_write_d = st_store_q;
                    mem_addr_d  = st_addr_q[ptr_d];
                    mem_wdata_d = st_store_q ? st_wdata_q[ptr_d] : '0;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, output registers and load capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            st_store_q <= 1'b0;
            st_mask_q  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            for (int unsigned i = 0; i < N_LANES; i++) begin
                st_addr_q[i]  <= '0;
                st_wdata_q[i] <= '0;
                rdata_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == FINISH);
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (latch) begin
                st_store_q <= is_store;
                st_mask_q  <= lane_mask;
                st_addr_q  <= in_addr;
                st_wdata_q <= in_wdata;
            end
            if (state_q == ACCESS && !st_store_q) begin
                rdata_q[ptr_q] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with a behavioural single-port memory.
module tb_lsu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_store;
    logic [3:0]  lane_mask;
    logic [31:0] lane_addr;
    logic [31:0] lane_wdata;
    logic        busy;
    logic        done;
    logic [31:0] lane_rdata;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256] = '{default: 8'h00};

    int vectors = 0;
    int errs    = 0;

    lsu_sequencer #(
        .N_LANES(4),
        .DATA_WORD_LENGTH(8),
        .DATAMEM_ADDR_WIDTH(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .is_store   (is_store),
        .lane_mask  (lane_mask),
        .lane_addr  (lane_addr),
        .lane_wdata (lane_wdata),
        .busy       (busy),
        .done       (done),
        .lane_rdata (lane_rdata),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on the clock edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        is_store   = 1'b0;
        lane_mask  = 4'h0;
        lane_addr  = 32'h0;
        lane_wdata = 32'h0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(mem_write), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rdata", 64'(lane_rdata), 64'd0);
        reset_n = 1'b1;
        tick();

        // Full 4-lane store
        is_store   = 1'b1;
        lane_mask  = 4'b1111;
        lane_addr  = 32'h03020100;
        lane_wdata = 32'hDDCCBBAA;
        start      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            chk("st_we", 64'(mem_write), 64'd1);
            chk("st_addr", 64'(mem_addr), 64'(i));
            chk("st_wdata", 64'(mem_wdata), 64'(8'hAA + 8'h11 * i));
            chk("st_busy", 64'(busy), 64'd1);
            chk("st_done", 64'(done), 64'd0);
        end
        tick();
        chk("st_done5", 64'(done), 64'd1);
        chk("st_we5", 64'(mem_write), 64'd0);
        chk("st_addr5", 64'(mem_addr), 64'd0);
        tick();
        chk("st_done6", 64'(done), 64'd0);
        chk("st_busy6", 64'(busy), 64'd0);
        chk("st_mem", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'hDDCCBBAA);

        // Sparse load: lane1 @2, lane3 @0
        is_store   = 1'b0;
        lane_mask  = 4'b1010;
        lane_addr  = 32'h00090209;
        lane_wdata = 32'h0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_addr1", 64'(mem_addr), 64'd2);
        chk("ld_we1", 64'(mem_write), 64'd0);
        tick();
        chk("ld_addr2", 64'(mem_addr), 64'd0);
        chk("ld_done2", 64'(done), 64'd0);
        tick();
        chk("ld_done3", 64'(done), 64'd1);
        chk("ld_rdata", 64'(lane_rdata), 64'hAA00CC00);
        tick();

        // Zero mask
        lane_mask = 4'b0000;
        is_store  = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("zm_done", 64'(done), 64'd1);
        chk("zm_busy", 64'(busy), 64'd1);
        chk("zm_we", 64'(mem_write), 64'd0);
        chk("zm_addr", 64'(mem_addr), 64'd0);
        tick();
        chk("zm_done2", 64'(done), 64'd0);
        chk("zm_busy2", 64'(busy), 64'd0);

        // Store collision: lanes 0 and 2 both to address 5
        is_store   = 1'b1;
        lane_mask  = 4'b0101;
        lane_addr  = 32'h00050005;
        lane_wdata = 32'h00220011;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("col_wdata1", 64'(mem_wdata), 64'h11);
        tick();
        chk("col_wdata2", 64'(mem_wdata), 64'h22);
        tick();
        chk("col_done", 64'(done), 64'd1);
        chk("col_mem", 64'(mem[5]), 64'h22);
        tick();
        is_store  = 1'b0;
        lane_mask = 4'b0001;
        lane_addr = 32'h00000005;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("col_lddone", 64'(done), 64'd1);
        chk("col_rdata", 64'(lane_rdata), 64'hAA00CC22);
        tick();

        // start held high; inputs change while busy
        is_store   = 1'b1;
        lane_mask  = 4'b0011;
        lane_addr  = 32'h00000706;
        lane_wdata = 32'h00004433;
        start      = 1'b1;
        tick();
        is_store   = 1'b0;
        lane_mask  = 4'b1111;
        lane_addr  = 32'h06060606;
        lane_wdata = 32'hFFFFFFFF;
        chk("hold_addr1", 64'(mem_addr), 64'd6);
        chk("hold_wdata1", 64'(mem_wdata), 64'h33);
        chk("hold_we1", 64'(mem_write), 64'd1);
        tick();
        chk("hold_addr2", 64'(mem_addr), 64'd7);
        chk("hold_wdata2", 64'(mem_wdata), 64'h44);
        tick();
        chk("hold_done", 64'(done), 64'd1);
        chk("hold_mem", 64'({mem[7], mem[6]}), 64'h4433);
        tick();
        chk("hold_idle", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        chk("hold2_busy", 64'(busy), 64'd1);
        chk("hold2_we", 64'(mem_write), 64'd0);
        chk("hold2_addr", 64'(mem_addr), 64'd6);
        tick();
        tick();
        tick();
        chk("hold2_done_early", 64'(done), 64'd0);
        tick();
        chk("hold2_done", 64'(done), 64'd1);
        chk("hold2_rdata", 64'(lane_rdata), 64'h33333333);
        tick();

        // Reset in the middle of a 4-lane store
        is_store   = 1'b1;
        lane_mask  = 4'b1111;
        lane_addr  = 32'h13121110;
        lane_wdata = 32'h99999999;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ab_addr", 64'(mem_addr), 64'h11);
        reset_n = 1'b0;
        #1;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_we", 64'(mem_write), 64'd0);
        chk("ab_rdata", 64'(lane_rdata), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        tick();
        chk("ab_done2", 64'(done), 64'd0);
        chk("ab_mem10", 64'(mem[8'h10]), 64'h99);
        chk("ab_mem11", 64'(mem[8'h11]), 64'h00);
        reset_n = 1'b1;
        tick();
        chk("ab_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
